// File: rtl/mv_avg_multi_ch.sv
// N-channel moving average, run-time power-of-two window.
// Per-channel circular history, clear and restart-on-length-change.
// Ports: clk, rstn (sync, active-low), log2_len (clamped window exp),
//   clr (sync clear), data_in/data_in_valid (packed signed samples),
//   data_out/data_out_valid (packed averages, 1-cycle latency),
//   window_full (2^L samples seen since last restart).
module mv_avg_multi_ch #(
  parameter int NUM_CH       = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int LOG2_MAX_LEN = 6,
  parameter int LW           = $clog2(LOG2_MAX_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [LW-1:0]                log2_len,
  input  logic                         clr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic                         data_in_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic                         data_out_valid,
  output logic                         window_full
);

  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 1 << LOG2_MAX_LEN;
  localparam int ACC   = DATA_WIDTH + LOG2_MAX_LEN;
  localparam int PW    = LOG2_MAX_LEN;
  localparam int FW    = LOG2_MAX_LEN + 1;

  logic [LW-1:0] len_c;
  logic [LW-1:0] len_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [FW-1:0] fill_q;
  logic [FW-1:0] fill_nxt;
  logic [FW-1:0] win;
  logic          warm;
  logic          restart;
  logic          accept;

  logic signed [ACC-1:0] acc_q   [NUM_CH];
  logic signed [ACC-1:0] acc_nxt [NUM_CH];
  logic signed [ACC-1:0] new_s   [NUM_CH];
  logic signed [ACC-1:0] old_s   [NUM_CH];
  logic [DW-1:0]         hist    [NUM_CH][DEPTH];
  logic [NUM_CH*DW-1:0]  dout_nxt;

  assign len_c = (log2_len > LW'(LOG2_MAX_LEN)) ?
                 LW'(LOG2_MAX_LEN) : log2_len;

  assign restart = clr | (len_c != len_q);
  assign accept  = data_in_valid & ~restart;

  assign win  = FW'(1) << len_q;
  assign warm = (fill_q != win);

  // At full depth the low bits of win are zero, so the read
  // address equals the write address; the array read below
  // returns the pre-write value (read-before-write).
  assign rd_ptr   = wr_ptr - win[PW-1:0];
  assign fill_nxt = warm ? fill_q + FW'(1) : fill_q;

  always_comb begin
    dout_nxt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      new_s[k] = ACC'($signed(data_in[k*DW +: DW]));
      old_s[k] = warm ? '0 : ACC'($signed(hist[k][rd_ptr]));
      acc_nxt[k] = acc_q[k] + new_s[k] - old_s[k];
      dout_nxt[k*DW +: DW] = DW'(acc_nxt[k] >>> len_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && accept) begin
      for (int k = 0; k < NUM_CH; k++)
        hist[k][wr_ptr] <= data_in[k*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      len_q          <= len_c;
      wr_ptr         <= '0;
      fill_q         <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      window_full    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++)
        acc_q[k] <= '0;
    end else begin
      unique case (1'b1)
        restart: begin
          len_q          <= len_c;
          wr_ptr         <= '0;
          fill_q         <= '0;
          data_out_valid <= 1'b0;
          window_full    <= 1'b0;
          for (int k = 0; k < NUM_CH; k++)
            acc_q[k] <= '0;
        end
        accept: begin
          wr_ptr         <= wr_ptr + PW'(1);
          fill_q         <= fill_nxt;
          data_out       <= dout_nxt;
          data_out_valid <= 1'b1;
          window_full    <= (fill_nxt == win);
          for (int k = 0; k < NUM_CH; k++)
            acc_q[k] <= acc_nxt[k];
        end
        default: begin
          data_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mv_avg_multi_ch.sv
// Scoreboard bench for mv_avg_multi_ch.
// Stimulus pushes expectations; a monitor pops on each strobe.
module tb_mv_avg_multi_ch;

  localparam int NC = 2;
  localparam int DW = 16;
  localparam int LM = 6;
  localparam int LW = $clog2(LM + 1);

  logic               clk = 1'b0;
  logic               rstn;
  logic [LW-1:0]      log2_len;
  logic               clr;
  logic [NC*DW-1:0]   data_in;
  logic               data_in_valid;
  logic [NC*DW-1:0]   data_out;
  logic               data_out_valid;
  logic               window_full;

  mv_avg_multi_ch #(
    .NUM_CH(NC),
    .DATA_WIDTH(DW),
    .LOG2_MAX_LEN(LM)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .log2_len(log2_len),
    .clr(clr),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .window_full(window_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint d0;
    longint d1;
    logic   wf;
    int     cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int t1_e[6] = '{25, 50, 75, 100, 100, 100};
  int t3_i[9] = '{0, 0, 0, 0, 40, 40, 40, 40, 40};
  int t3_e[9] = '{0, 0, 0, 0, 10, 20, 30, 40, 40};
  int t5_e[8] = '{10, 20, 30, 40, 50, 60, 70, 80};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint ch(input int k);
    return longint'($signed(data_out[k*DW +: DW]));
  endfunction

  // Constant-input ramp: floor(min(n,2^l)*c / 2^l).
  function automatic longint ramp(input longint c,
                                  input int n,
                                  input int l);
    longint d = longint'(1) << l;
    longint m = (n < d) ? longint'(n) : d;
    longint a = m * c;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  always @(posedge clk) begin
    #1;
    if (data_out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got strobe expected none");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ch0", ch(0), e.d0);
        chk("ch1", ch(1), e.d1);
        chk("window_full", longint'(window_full), longint'(e.wf));
        chk("latency_cycle", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  task automatic send(input int a, input int b,
                      input longint ea, input longint eb,
                      input logic ewf);
    exp_t e;
    @(negedge clk);
    data_in       = {DW'(b), DW'(a)};
    data_in_valid = 1'b1;
    e.d0  = ea;
    e.d1  = eb;
    e.wf  = ewf;
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    idle(1);
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               q.size());
      q.delete();
    end
  endtask

  task automatic set_len(input int l);
    @(negedge clk);
    data_in_valid = 1'b0;
    log2_len      = LW'(l);
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn          = 1'b0;
    clr           = 1'b0;
    log2_len      = LW'(2);
    data_in       = '0;
    data_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", longint'(data_out), 0);
    chk("rst_valid", longint'(data_out_valid), 0);
    chk("rst_wf", longint'(window_full), 0);
    @(negedge clk);
    rstn = 1'b1;

    // L=2, constant 100 ramp
    for (int i = 0; i < 6; i++)
      send(100, 0, t1_e[i], 0, i >= 3);
    drain();

    // L=1, channel independence, arithmetic floor
    set_len(1);
    chk("len_chg_wf", longint'(window_full), 0);
    send(1, -1, 0, -1, 1'b0);
    send(1, -1, 1, -1, 1'b1);
    send(1, -1, 1, -1, 1'b1);
    drain();

    // L=2, zeros then 40s, back-to-back
    set_len(2);
    for (int i = 0; i < 9; i++)
      send(t3_i[i], 0, t3_e[i], 0, i >= 3);
    drain();

    // clr mid-stream with a sample present: dropped, output held
    @(negedge clk);
    clr           = 1'b1;
    data_in       = {DW'(7), DW'(500)};
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_valid", longint'(data_out_valid), 0);
    chk("clr_wf", longint'(window_full), 0);
    chk("clr_hold_ch0", ch(0), 40);
    @(negedge clk);
    clr           = 1'b0;
    data_in_valid = 1'b0;

    // same sequence with random gaps
    for (int i = 0; i < 9; i++) begin
      send(t3_i[i], 0, t3_e[i], 0, i >= 3);
      idle($urandom_range(0, 3));
    end
    drain();

    // log2_len above max clamps to 6; full-scale, pointer wrap
    set_len(7);
    chk("l6_wf_start", longint'(window_full), 0);
    for (int n = 1; n <= 70; n++)
      send(32767, -32768, ramp(32767, n, 6),
           ramp(-32768, n, 6), n >= 64);
    drain();
    chk("l6_final_ch0", ch(0), 32767);
    chk("l6_final_ch1", ch(1), -32768);
    set_len(6);
    chk("clamp_no_restart_wf", longint'(window_full), 1);

    // change 2 -> 3 with valid high in the change cycle
    set_len(2);
    for (int i = 0; i < 5; i++)
      send(100, 0, t1_e[i], 0, i >= 3);
    drain();
    @(negedge clk);
    log2_len      = LW'(3);
    data_in       = {DW'(0), DW'(999)};
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("chg_valid", longint'(data_out_valid), 0);
    chk("chg_wf", longint'(window_full), 0);
    for (int i = 0; i < 8; i++)
      send(80, 0, t5_e[i], 0, i >= 7);
    drain();

    // rstn mid-stream
    set_len(2);
    send(100, 0, 25, 0, 1'b0);
    send(100, 0, 50, 0, 1'b0);
    drain();
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_data_out", longint'(data_out), 0);
    chk("mid_rst_valid", longint'(data_out_valid), 0);
    chk("mid_rst_wf", longint'(window_full), 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++)
      send(100, 0, t1_e[i], 0, i >= 3);
    drain();

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mv_avg_multi_ch.md
Name: mv_avg_multi_ch

Overview:
- N-channel moving-average filter with a window length selectable at run time as a power of two, up to 2^LOG2_MAX_LEN.
- Successor to the fixed-window dual-channel averager in the rx_intf signal-strength path.
- Uses an internal per-channel circular history buffer, with no vendor FIFO primitive.
- Adds a window-fill status flag, a synchronous clear, and a safe restart when the window length changes.

Parameters:
- NUM_CH, 2, number of independent channels sharing one valid strobe.
- DATA_WIDTH, 16, signed sample width per channel.
- LOG2_MAX_LEN, 6, log2 of maximum window length; history depth per channel is 2^LOG2_MAX_LEN.
- LW, $clog2(LOG2_MAX_LEN+1), width of log2_len (derived, not overridden).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- log2_len  in  LW  requested window length exponent L; values above LOG2_MAX_LEN are clamped to LOG2_MAX_LEN.
- clr  in  1  synchronous clear of the averaging state.
- data_in  in  NUM_CH*DATA_WIDTH  signed samples; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- data_in_valid  in  1  one sample per channel is accepted on each cycle it is high.
- data_out  out  NUM_CH*DATA_WIDTH  signed averages, same packing as data_in.
- data_out_valid  out  1  one-cycle strobe per accepted sample.
- window_full  out  1  high once 2^L samples have been accumulated since the last restart.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - data_out=0, data_out_valid=0, window_full=0.
  - Accumulators, write pointer and fill counter all go to 0.
  - len_q is set to the clamped log2_len.
  - History contents need not be cleared.
- Restart condition: clr=1, or clamped log2_len != len_q.
  - On the next edge: accumulators, pointer and fill count go to 0, window_full=0, data_out_valid=0, len_q is loaded.
  - data_out holds its previous value.
  - A sample presented in the restart cycle is dropped. Restart has priority over data_in_valid.
- Accept (data_in_valid=1, no restart). For each channel k:
  - new = data_in[k], sign-extended to ACC = DATA_WIDTH+LOG2_MAX_LEN bits.
  - old = history[k][(wr_ptr - 2^len_q) mod 2^LOG2_MAX_LEN], sign-extended; old is forced to 0 while fill < 2^len_q.
  - acc[k] <= acc[k] + new - old.
  - history[k][wr_ptr] <= data_in[k].
  - wr_ptr increments and wraps at 2^LOG2_MAX_LEN; fill increments and saturates at 2^len_q.
- Output, registered with latency 1:
  - data_out[k] = (acc_next[k] >>> len_q), taking the low DATA_WIDTH bits. The shift is arithmetic (floor toward minus infinity).
  - data_out_valid is pulsed for exactly one cycle per accepted sample.
  - data_out holds between strobes.
- During warm-up (fill < 2^L) the output is the partial sum divided by 2^L: a ramp, no gating. window_full rises on the same edge as the output that completes the 2^L-th sample.
- Width rule: |acc| <= 2^L * 2^(DATA_WIDTH-1), so ACC bits never overflow. Full-scale inputs therefore reproduce exactly.
- L=0: output equals input delayed by one cycle; window_full rises on the first sample.
- Gaps in data_in_valid do not affect state. Back-to-back valids every cycle are supported with no bubbles.
- old is read in the same cycle it is used (combinational/distributed read). The read address never equals the write address when len_q >= 1 and fill = 2^len_q < depth. With len_q = LOG2_MAX_LEN, the read and write addresses coincide; read-before-write is required there.

Test Plan:
- NUM_CH=2, DATA_WIDTH=16, LOG2_MAX_LEN=6, L=2, ch0 constant 100 for 6 samples:
  - ch0 out = 25, 50, 75, 100, 100, 100.
  - window_full rises with the 4th strobe.
  - Each strobe arrives 1 cycle after its input valid.
- L=1, ch1 constant -1:
  - out = -1, -1, ... (arithmetic floor; -1 >>> 1 = -1).
  - Simultaneously ch0 = +1 gives 0, 1, 1, confirming channel independence.
- L=2, ch0 four 0s then 40s:
  - out = 0, 0, 0, 0, 10, 20, 30, 40, 40.
  - Random idle cycles inserted between valids give an identical sequence.
- L=6, ch0=32767 and ch1=-32768 for 70 samples:
  - Final outputs are exactly 32767 and -32768, with no wrap.
  - Exercises pointer wrap and the read-before-write case.
- Change log2_len from 2 to 3 mid-stream with valid high in that cycle:
  - That sample is dropped, data_out_valid=0 for that cycle, and window_full=0.
  - Following constant 80 gives 10, 20, ..., 80.
- Assert clr and rstn=0 each in separate mid-stream runs:
  - clr: state restarts and data_out holds its previous value.
  - rstn: data_out=0, valid=0, window_full=0.
  - Next 100-constant stream at L=2 restarts at 25.
